// File: rtl/nbout_psum_ctrl_pkg.sv
// Shared definitions for the output-neuron partial-sum controller:
// the controller state encoding and the default width constants.
package nbout_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        ACCUM = 3'd2,
        WB    = 3'd3,
        RESP  = 3'd4
    } state_t;

    localparam int DEF_BIT_WIDTH  = 16;
    localparam int DEF_TN         = 16;
    localparam int DEF_BUF_DEPTH  = 16;
    localparam int DEF_PASS_WIDTH = 8;

endpackage

// File: rtl/nbout_psum_ctrl_if.sv
// Bus bundle for the partial-sum controller: command channel, accumulator
// seed/feedback path and the valid/ready result stream.
interface nbout_psum_ctrl_if
    import nbout_pkg::*;
#(
    parameter int BIT_WIDTH  = DEF_BIT_WIDTH,
    parameter int Tn         = DEF_TN,
    parameter int BUF_DEPTH  = DEF_BUF_DEPTH,
    parameter int PASS_WIDTH = DEF_PASS_WIDTH
);
    localparam int PW = Tn * BIT_WIDTH;
    localparam int AW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;

    logic                  i_cmd_valid;
    logic                  o_cmd_ready;
    logic [AW-1:0]         i_cmd_addr;
    logic [PASS_WIDTH-1:0] i_cmd_passes;
    logic                  i_cmd_init_zero;
    logic                  i_cmd_last;
    logic [PW-1:0]         o_partial_sum;
    logic                  o_load_partial_sum;
    logic [PW-1:0]         i_output;
    logic                  o_res_valid;
    logic                  i_res_ready;
    logic [PW-1:0]         o_res_data;

    // The master side issues commands, models the accumulator and sinks results.
    modport master (
        output i_cmd_valid, i_cmd_addr, i_cmd_passes, i_cmd_init_zero, i_cmd_last,
        output i_output, i_res_ready,
        input  o_cmd_ready, o_partial_sum, o_load_partial_sum, o_res_valid, o_res_data
    );

    modport slave (
        input  i_cmd_valid, i_cmd_addr, i_cmd_passes, i_cmd_init_zero, i_cmd_last,
        input  i_output, i_res_ready,
        output o_cmd_ready, o_partial_sum, o_load_partial_sum, o_res_valid, o_res_data
    );

endinterface

// File: rtl/nbout_psum_buf.sv
// Partial-sum register file: one combinational read port, one synchronous
// write port, whole array cleared by the asynchronous reset.
module nbout_psum_buf #(
    parameter int PW    = 256,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] rd_addr,
    output logic [PW-1:0] rd_data,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [PW-1:0] wr_data
);

    logic [PW-1:0] mem [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/nbout_psum_ctrl.sv
// Output-neuron partial-sum controller: seeds the accumulator, waits N passes,
// writes the result back and optionally streams it out (ReLU when NBOUT_RELU_EN).
module nbout_psum_ctrl
    import nbout_pkg::*;
#(
    parameter int BIT_WIDTH  = DEF_BIT_WIDTH,
    parameter int Tn         = DEF_TN,
    parameter int BUF_DEPTH  = DEF_BUF_DEPTH,
    parameter int PASS_WIDTH = DEF_PASS_WIDTH
) (
    input logic              clk,
    input logic              rst_n,
    nbout_psum_ctrl_if.slave bus
);

    localparam int PW = Tn * BIT_WIDTH;
    localparam int AW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;

    state_t                state;
    logic                  cmd_ready;
    logic [AW-1:0]         addr_q;
    logic [PASS_WIDTH-1:0] passes_q;
    logic [PASS_WIDTH-1:0] cnt;
    logic                  init_zero_q;
    logic                  last_q;
    logic                  load_q;
    logic                  res_valid;
    logic [PW-1:0]         res_data;
    logic [PW-1:0]         rd_data;
    logic [PW-1:0]         relu_data;
    logic                  wr_en;

    assign wr_en = (state == WB);

    nbout_psum_buf #(
        .PW    (PW),
        .DEPTH (BUF_DEPTH),
        .AW    (AW)
    ) u_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .rd_addr (addr_q),
        .rd_data (rd_data),
        .wr_en   (wr_en),
        .wr_addr (addr_q),
        .wr_data (bus.i_output)
    );

    // Only the streamed copy is clamped; the buffer always keeps the raw sum.
    always_comb begin
        relu_data = bus.i_output;
`ifdef NBOUT_RELU_EN
        for (int l = 0; l < Tn; l++) begin
            if (bus.i_output[l*BIT_WIDTH + BIT_WIDTH - 1]) begin
                relu_data[l*BIT_WIDTH +: BIT_WIDTH] = '0;
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cmd_ready   <= 1'b1;
            addr_q      <= '0;
            passes_q    <= '0;
            cnt         <= '0;
            init_zero_q <= 1'b0;
            last_q      <= 1'b0;
            load_q      <= 1'b0;
            res_valid   <= 1'b0;
            res_data    <= '0;
        end else begin
            load_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.i_cmd_valid && cmd_ready) begin
                        addr_q      <= bus.i_cmd_addr;
                        passes_q    <= bus.i_cmd_passes;
                        cnt         <= bus.i_cmd_passes;
                        init_zero_q <= bus.i_cmd_init_zero;
                        last_q      <= bus.i_cmd_last;
                        cmd_ready   <= 1'b0;
                        load_q      <= 1'b1;
                        state       <= LOAD;
                    end
                end
                LOAD: begin
                    state <= (passes_q == '0) ? WB : ACCUM;
                end
                ACCUM: begin
                    if (cnt == PASS_WIDTH'(1)) begin
                        state <= WB;
                    end else begin
                        cnt <= cnt - PASS_WIDTH'(1);
                    end
                end
                WB: begin
                    if (last_q) begin
                        res_data  <= relu_data;
                        res_valid <= 1'b1;
                        state     <= RESP;
                    end else begin
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                RESP: begin
                    if (bus.i_res_ready) begin
                        res_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    cmd_ready <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

    assign bus.o_cmd_ready        = cmd_ready;
    assign bus.o_load_partial_sum = load_q;
    assign bus.o_partial_sum      = (load_q && !init_zero_q) ? rd_data : '0;
    assign bus.o_res_valid        = res_valid;
    assign bus.o_res_data         = res_data;

endmodule

// File: tb/tb_nbout_psum_ctrl.sv
// Directed bench for nbout_psum_ctrl: a table of commands with hand-computed
// seeds/results plus hand sequences for back-pressure and mid-operation reset.
module tb_nbout_psum_ctrl;

    localparam int BW    = 16;
    localparam int TN    = 4;
    localparam int DEPTH = 8;
    localparam int PASSW = 8;
    localparam int PW    = TN * BW;
    localparam int AW    = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    nbout_psum_ctrl_if #(
        .BIT_WIDTH  (BW),
        .Tn         (TN),
        .BUF_DEPTH  (DEPTH),
        .PASS_WIDTH (PASSW)
    ) bus ();

    nbout_psum_ctrl #(
        .BIT_WIDTH  (BW),
        .Tn         (TN),
        .BUF_DEPTH  (DEPTH),
        .PASS_WIDTH (PASSW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // Accumulator stand-in: latches the seed on the load strobe, else adds inc per lane.
    logic signed [BW-1:0] inc;
    logic [PW-1:0]        acc;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (bus.o_load_partial_sum) begin
            acc <= bus.o_partial_sum;
        end else begin
            for (int l = 0; l < TN; l++) begin
                acc[l*BW +: BW] <= acc[l*BW +: BW] + inc;
            end
        end
    end

    assign bus.i_output = acc;

    typedef struct {
        logic [AW-1:0]        addr;
        logic [PASSW-1:0]     passes;
        logic                 init_zero;
        logic                 last;
        logic signed [BW-1:0] inc;
        int                   hold;
        logic signed [BW-1:0] exp_seed;
        logic signed [BW-1:0] exp_res;
    } vec_t;

    int vecCount  = 0;
    int missCount = 0;

    function automatic logic [PW-1:0] rep(input logic signed [BW-1:0] v);
        logic [PW-1:0] r;
        for (int l = 0; l < TN; l++) r[l*BW +: BW] = v;
        return r;
    endfunction

    function automatic logic signed [BW-1:0] relu(input logic signed [BW-1:0] v);
`ifdef NBOUT_RELU_EN
        return (v < 0) ? '0 : v;
`else
        return v;
`endif
    endfunction

    task automatic checkOutput(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        vecCount++;
        if (act !== exp) begin
            missCount++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        int            cyc;
        int            busy;
        logic [PW-1:0] held;
        cyc = 0;
        while (!bus.o_cmd_ready && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
        checkOutput("cmd_ready before issue", PW'(bus.o_cmd_ready), PW'(1));
        bus.i_cmd_valid     = 1'b1;
        bus.i_cmd_addr      = v.addr;
        bus.i_cmd_passes    = v.passes;
        bus.i_cmd_init_zero = v.init_zero;
        bus.i_cmd_last      = v.last;
        inc                 = v.inc;
        @(negedge clk);
        bus.i_cmd_valid = 1'b0;
        checkOutput("load strobe in LOAD", PW'(bus.o_load_partial_sum), PW'(1));
        checkOutput("seed in LOAD", bus.o_partial_sum, rep(v.exp_seed));
        checkOutput("cmd_ready low in LOAD", PW'(bus.o_cmd_ready), PW'(0));
        busy = 1;
        @(negedge clk);
        checkOutput("load strobe after LOAD", PW'(bus.o_load_partial_sum), PW'(0));
        checkOutput("seed after LOAD", bus.o_partial_sum, '0);
        while (!bus.o_cmd_ready && !bus.o_res_valid && busy < 400) begin
            busy++;
            @(negedge clk);
        end
        checkOutput("busy cycles", PW'(busy), PW'(int'(v.passes) + 2));
        if (v.last) begin
            checkOutput("res_valid", PW'(bus.o_res_valid), PW'(1));
            checkOutput("res_data", bus.o_res_data, rep(relu(v.exp_res)));
            held = bus.o_res_data;
            for (int h = 0; h < v.hold; h++) begin
                bus.i_cmd_valid = 1'b1;
                @(negedge clk);
                checkOutput("res_valid held", PW'(bus.o_res_valid), PW'(1));
                checkOutput("res_data stable", bus.o_res_data, held);
                checkOutput("cmd stalled in RESP", PW'(bus.o_cmd_ready), PW'(0));
            end
            bus.i_cmd_valid = 1'b0;
            bus.i_res_ready = 1'b1;
            @(negedge clk);
            bus.i_res_ready = 1'b0;
            checkOutput("res_valid after handshake", PW'(bus.o_res_valid), PW'(0));
            checkOutput("cmd_ready after handshake", PW'(bus.o_cmd_ready), PW'(1));
        end else begin
            checkOutput("no result when not last", PW'(bus.o_res_valid), PW'(0));
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        vec_t vecs[11];
        vec_t v;
        vecs[0]  = '{3'd2, 8'd3,   1'b1, 1'b1, 16'sd5,   0, 16'sd0,   16'sd15};
        vecs[1]  = '{3'd2, 8'd2,   1'b0, 1'b1, 16'sd5,   4, 16'sd15,  16'sd25};
        vecs[2]  = '{3'd5, 8'd1,   1'b1, 1'b0, 16'sd7,   0, 16'sd0,   16'sd7};
        vecs[3]  = '{3'd5, 8'd0,   1'b0, 1'b0, 16'sd0,   0, 16'sd7,   16'sd7};
        vecs[4]  = '{3'd5, 8'd1,   1'b0, 1'b1, 16'sd0,   0, 16'sd7,   16'sd7};
        vecs[5]  = '{3'd3, 8'd1,   1'b1, 1'b1, -16'sd3,  0, 16'sd0,   -16'sd3};
        vecs[6]  = '{3'd3, 8'd0,   1'b0, 1'b1, 16'sd0,   0, -16'sd3,  -16'sd3};
        vecs[7]  = '{3'd7, 8'd255, 1'b1, 1'b0, 16'sd1,   0, 16'sd0,   16'sd255};
        vecs[8]  = '{3'd7, 8'd0,   1'b0, 1'b1, 16'sd0,   0, 16'sd255, 16'sd255};
        vecs[9]  = '{3'd2, 8'd1,   1'b1, 1'b1, 16'sd100, 2, 16'sd0,   16'sd100};
        vecs[10] = '{3'd2, 8'd0,   1'b0, 1'b1, 16'sd0,   0, 16'sd100, 16'sd100};

        bus.i_cmd_valid     = 1'b0;
        bus.i_cmd_addr      = '0;
        bus.i_cmd_passes    = '0;
        bus.i_cmd_init_zero = 1'b0;
        bus.i_cmd_last      = 1'b0;
        bus.i_res_ready     = 1'b0;
        inc                 = '0;
        rst_n               = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset cmd_ready", PW'(bus.o_cmd_ready), PW'(1));
        checkOutput("reset res_valid", PW'(bus.o_res_valid), PW'(0));
        checkOutput("reset res_data", bus.o_res_data, '0);
        checkOutput("reset load strobe", PW'(bus.o_load_partial_sum), PW'(0));
        checkOutput("reset partial_sum", bus.o_partial_sum, '0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 11; i++) begin
            applyStimulus(vecs[i]);
        end

        // Abort during ACCUM: buffer entry 4 holds 9 beforehand and must come back as 0.
        v = '{3'd4, 8'd1, 1'b1, 1'b0, 16'sd9, 0, 16'sd0, 16'sd9};
        applyStimulus(v);
        bus.i_cmd_valid     = 1'b1;
        bus.i_cmd_addr      = 3'd4;
        bus.i_cmd_passes    = 8'd5;
        bus.i_cmd_init_zero = 1'b0;
        bus.i_cmd_last      = 1'b1;
        inc                 = 16'sd1;
        @(negedge clk);
        bus.i_cmd_valid = 1'b0;
        checkOutput("seed before abort", bus.o_partial_sum, rep(16'sd9));
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("abort cmd_ready", PW'(bus.o_cmd_ready), PW'(1));
        checkOutput("abort res_valid", PW'(bus.o_res_valid), PW'(0));
        checkOutput("abort res_data", bus.o_res_data, '0);
        checkOutput("abort load strobe", PW'(bus.o_load_partial_sum), PW'(0));
        checkOutput("abort partial_sum", bus.o_partial_sum, '0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        v = '{3'd4, 8'd0, 1'b0, 1'b1, 16'sd0, 0, 16'sd0, 16'sd0};
        applyStimulus(v);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule

// File: doc/nbout_psum_ctrl.md
NBOUT_PSUM_CTRL -- requirements
Module: nbout_psum_ctrl

Interface
REQ-001 Parameter BIT_WIDTH, default 16, width of one signed output-neuron lane.
REQ-002 Parameter Tn, default 16, number of output lanes; partial-sum vector width PW = Tn*BIT_WIDTH.
REQ-003 Parameter BUF_DEPTH, default 16, number of partial-sum entries; AW = clog2(BUF_DEPTH).
REQ-004 Parameter PASS_WIDTH, default 8, width of the pass count.
REQ-005 clk  input  1  single clock, rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 i_cmd_valid  input  1  command offered.
REQ-008 o_cmd_ready  output  1  command accepted when high with i_cmd_valid.
REQ-009 i_cmd_addr  input  AW  partial-sum entry index.
REQ-010 i_cmd_passes  input  PASS_WIDTH  accumulation cycles N.
REQ-011 i_cmd_init_zero  input  1  1: start from zero; 0: start from the stored entry.
REQ-012 i_cmd_last  input  1  final pass group; the result is emitted.
REQ-013 o_partial_sum  output  PW  seed vector to the accumulator.
REQ-014 o_load_partial_sum  output  1  accumulator load strobe.
REQ-015 i_output  input  PW  accumulator register value.
REQ-016 o_res_valid / i_res_ready / o_res_data  output/input/output  1/1/PW  result stream, valid/ready.

Function
REQ-017 States: IDLE, LOAD, ACCUM, WB, RESP; o_cmd_ready SHALL be 1 only in IDLE.
REQ-018 On a handshake in IDLE, the block SHALL register addr, passes, init_zero and last, then enter LOAD.
REQ-019 LOAD lasts 1 cycle and drives o_load_partial_sum=1, with o_partial_sum = 0 if init_zero, else buf[addr]; in all other states both outputs SHALL be 0.
REQ-020 From LOAD, the block SHALL enter ACCUM for exactly N cycles, then WB; if N=0, it SHALL go from LOAD directly to WB.
REQ-021 WB lasts 1 cycle: the block SHALL write i_output into buf[addr]. If last=1, it SHALL also capture i_output into o_res_data, set o_res_valid and enter RESP; otherwise it SHALL return to IDLE.
REQ-022 Timing: the seed is latched by the accumulator at the end of LOAD; WB samples i_output after exactly N accumulation edges.
REQ-023 In RESP, o_res_valid and o_res_data SHALL stay stable until i_res_ready=1; after the handshake the block SHALL enter IDLE. A handshake on the entry cycle of RESP is legal.
REQ-024 A buffer write in WB and a read of the same addr in a later LOAD SHALL return the new value; no forwarding is needed otherwise.
REQ-025 Lane arithmetic: no arithmetic is performed on the data path except ReLU (REQ-029); values pass unchanged.

Reset
REQ-026 rst_n low SHALL force: IDLE, all buffer entries 0, o_res_valid 0, o_res_data 0, o_load_partial_sum 0, o_partial_sum 0, and registered command fields 0.
REQ-027 Reset asserted mid-operation SHALL abort the operation; an in-flight result is discarded and no buffer write occurs.

Configuration
REQ-028 Macro NBOUT_RELU_EN selects ReLU on the result stream.
REQ-029 With NBOUT_RELU_EN defined, each signed BIT_WIDTH lane of o_res_data SHALL be clamped to 0 when negative; the stored buf entry stays unclamped.
REQ-030 Without NBOUT_RELU_EN, o_res_data SHALL equal the captured i_output exactly.

Structure
REQ-031 Package nbout_pkg SHALL hold the state enum and the default-width constants.
REQ-032 Sub-module nbout_psum_buf SHALL implement the register file: 1 combinational read port, 1 synchronous write port, asynchronous clear.

Verification
REQ-033 Test: init_zero=1, N=3, last=1, accumulator adding 5 per lane per cycle -> o_res_data lanes = 15, and buf[2] = 15.
REQ-034 Test: addr=2, init_zero=0, N=2, +5/cycle, following REQ-033 -> LOAD drives 15; result lanes = 25.
REQ-035 Test: N=0, init_zero=0, last=0 on a stored value 7 -> no result; buf unchanged at 7; ready returns after 2 cycles.
REQ-036 Test: last=1, i_res_ready held low 4 cycles -> o_res_valid is held and data is stable; the next command is stalled until the handshake.
REQ-037 Test: NBOUT_RELU_EN defined, lane result -3 -> o_res_data lane = 0, buf lane = -3; without the macro, o_res_data lane = -3.
REQ-038 Test: rst_n pulsed low during ACCUM -> IDLE with all outputs 0; a following read of that addr in LOAD gives 0.
